// File: rtl/aes_encrypt_core.sv
// AES-128 encryption core. One full round per clock, round keys are
// loaded one per strobe from an external key schedule and held locally.
module aes_encrypt_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kx_valid,
  input  logic [3:0]   kx_round,
  input  logic [127:0] kx_key,
  output logic         keys_ready,
  output logic         key_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  typedef enum logic [1:0] {IDLE, READY, RUN, DONE} state_t;

  // S-box table, 0x63 in the top byte. The packed index runs 255..0 from
  // the top, so the entry for byte value b lives at index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t         state;
  state_t         state_next;
  logic [127:0]   round_key [0:10];
  logic [3:0]     exp_r;
  logic [3:0]     rnd;
  logic [127:0]   aes_state;

  logic           key_phase;
  logic           kx_first;
  logic           kx_next;
  logic           kx_bad;
  logic           kx_busy;
  logic           accept;

  logic [7:0]     sub_b   [16];
  logic [7:0]     shift_b [16];
  logic [7:0]     mix_b   [16];
  logic [127:0]   shifted;
  logic [127:0]   mixed;
  logic [127:0]   round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Classify the key strobe: restart at round 0, next expected round,
  // out-of-order error, or a strobe arriving while a block is in flight.
  always_comb begin
    key_phase = (state == IDLE) || (state == READY);
    kx_first  = kx_valid && key_phase && (kx_round == 4'd0);
    kx_next   = kx_valid && key_phase && (kx_round != 4'd0) &&
                (kx_round == exp_r) && (exp_r <= 4'd10);
    kx_bad    = kx_valid && key_phase && !kx_first && !kx_next;
    kx_busy   = kx_valid && !key_phase;
    accept    = in_valid && (state == READY) && !kx_valid;
  end

  assign in_ready  = (state == READY);
  assign out_block = aes_state;

  // SubBytes then ShiftRows; byte i of the block is row i%4, column i/4.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sub_b[i] = SBOX[~aes_state[127-8*i -: 8]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_b[4*c + r] = sub_b[4*((c + r) % 4) + r];
      end
    end
  end

  // MixColumns on each column, then pick the final-round path and add the key.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mix_b[4*c]   = xtime(shift_b[4*c]) ^ xtime(shift_b[4*c+1]) ^ shift_b[4*c+1] ^
                     shift_b[4*c+2] ^ shift_b[4*c+3];
      mix_b[4*c+1] = shift_b[4*c] ^ xtime(shift_b[4*c+1]) ^ xtime(shift_b[4*c+2]) ^
                     shift_b[4*c+2] ^ shift_b[4*c+3];
      mix_b[4*c+2] = shift_b[4*c] ^ shift_b[4*c+1] ^ xtime(shift_b[4*c+2]) ^
                     xtime(shift_b[4*c+3]) ^ shift_b[4*c+3];
      mix_b[4*c+3] = xtime(shift_b[4*c]) ^ shift_b[4*c] ^ shift_b[4*c+1] ^
                     shift_b[4*c+2] ^ xtime(shift_b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      shifted[127-8*i -: 8] = shift_b[i];
      mixed[127-8*i -: 8]   = mix_b[i];
    end
    round_out = ((rnd == 4'd10) ? shifted : mixed) ^ round_key[rnd];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; key traffic takes priority over a plaintext offer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, READY: begin
        if (kx_first || kx_bad) begin
          state_next = IDLE;
        end else if (kx_next && (kx_round == 4'd10)) begin
          state_next = READY;
        end else if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (rnd == 4'd10) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = READY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Key store, key status flags, and the round datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) begin
        round_key[i] <= '0;
      end
      exp_r      <= 4'd0;
      rnd        <= 4'd0;
      keys_ready <= 1'b0;
      key_err    <= 1'b0;
      out_valid  <= 1'b0;
      aes_state  <= '0;
    end else begin
      if (kx_first) begin
        round_key[0] <= kx_key;
        exp_r        <= 4'd1;
        keys_ready   <= 1'b0;
        key_err      <= 1'b0;
      end else if (kx_next) begin
        round_key[kx_round] <= kx_key;
        exp_r               <= exp_r + 4'd1;
        if (kx_round == 4'd10) begin
          keys_ready <= 1'b1;
        end
      end else if (kx_bad) begin
        key_err    <= 1'b1;
        keys_ready <= 1'b0;
        exp_r      <= 4'd0;
      end else if (kx_busy) begin
        key_err <= 1'b1;
      end

      if (accept) begin
        aes_state <= in_block ^ round_key[0];
        rnd       <= 4'd1;
      end else if (state == RUN) begin
        aes_state <= round_out;
        rnd       <= rnd + 4'd1;
        if (rnd == 4'd10) begin
          out_valid <= 1'b1;
        end
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core using FIPS-197 vectors.
module tb_aes_encrypt_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  // S-box for the bench key expansion; entry for byte b is at index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    logic [127:0] blk;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         kx_valid;
  logic [3:0]   kx_round;
  logic [127:0] kx_key;
  logic         keys_ready;
  logic         key_err;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  int           tests_run = 0;
  int           failures  = 0;
  int           cyc       = 0;
  exp_t         sb_q[$];
  logic [127:0] key_sched [11];
  logic         prev_valid;

  aes_encrypt_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kx_valid   (kx_valid),
    .kx_round   (kx_round),
    .kx_key     (kx_key),
    .keys_ready (keys_ready),
    .key_err    (key_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block)
  );

  // 100 MHz clock and a free-running edge counter for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; strobes drop again just after the edge.
  task automatic applyStimulus(input logic kv, input logic [3:0] kr, input logic [127:0] kk,
                               input logic iv, input logic [127:0] ib);
    kx_valid = kv;
    kx_round = kr;
    kx_key   = kk;
    in_valid = iv;
    in_block = ib;
    @(posedge clk);
    #1;
    kx_valid = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'd0, '0, 1'b0, '0);
  endtask

  // Reference key expansion producing the 11 round keys.
  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[~t[31:24]], SBOX[~t[23:16]], SBOX[~t[15:8]], SBOX[~t[7:0]]} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) key_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic sendKey(input int r);
    applyStimulus(1'b1, 4'(r), key_sched[r], 1'b0, '0);
  endtask

  task automatic loadKeys(input logic [127:0] key);
    expandKey(key);
    for (int r = 0; r < 11; r++) sendKey(r);
  endtask

  // Offer a block until accepted and push its expected ciphertext.
  task automatic sendBlock(input logic [127:0] pt, input logic [127:0] ct, output int acc);
    logic accepted;
    accepted = 1'b0;
    acc = -1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      accepted = in_ready;
      applyStimulus(1'b0, 4'd0, '0, 1'b1, pt);
      if (accepted) begin
        acc = cyc;
        sb_q.push_back('{ct, cyc});
      end
    end
    checkOutput("block_accept", 128'(accepted), 128'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) idle(1);
    checkOutput("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    idle(1);
  endtask

  // Monitor: compare every presented ciphertext, check latency on its first
  // cycle (counting the accepting edge), pop on the output handshake.
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_output", 128'(out_valid), 128'd0);
        end else begin
          if (!prev_valid) checkOutput("latency", 128'(cyc - sb_q[0].acc + 1), 128'd11);
          checkOutput("ciphertext", out_block, sb_q[0].blk);
          if (out_ready) sb_q.delete(0);
        end
      end
      prev_valid = rst_n && out_valid;
    end
  end

  initial begin
    int   acc1;
    int   acc2;
    logic saw;

    rst_n     = 1'b0;
    kx_valid  = 1'b0;
    kx_round  = 4'd0;
    kx_key    = '0;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b1;

    // Reset values.
    #12;
    checkOutput("reset_keys_ready", 128'(keys_ready), 128'd0);
    checkOutput("reset_key_err", 128'(key_err), 128'd0);
    checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_out_block", out_block, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // FIPS-197 C.1.
    loadKeys(C1_KEY);
    checkOutput("c1_keys_ready", 128'(keys_ready), 128'd1);
    checkOutput("c1_key_err", 128'(key_err), 128'd0);
    checkOutput("c1_in_ready", 128'(in_ready), 128'd1);
    sendBlock(C1_PT, C1_CT, acc1);
    drain();

    // FIPS-197 App. B, two blocks back to back.
    loadKeys(B_KEY);
    sendBlock(B_PT, B_CT, acc1);
    sendBlock(B_PT, B_CT, acc2);
    checkOutput("issue_interval", 128'(acc2 - acc1), 128'd12);
    drain();

    // Backpressure: hold out_ready low for five cycles in DONE.
    out_ready = 1'b0;
    sendBlock(B_PT, B_CT, acc1);
    saw = 1'b0;
    for (int i = 0; i < 20 && !saw; i++) begin
      saw = out_valid;
      if (!saw) idle(1);
    end
    checkOutput("bp_out_valid_seen", 128'(saw), 128'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'd0, '0, 1'b1, C1_PT);
      checkOutput("bp_stall_in_ready", 128'(in_ready), 128'd0);
      checkOutput("bp_stall_out_valid", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    idle(1);
    checkOutput("bp_release_in_ready", 128'(in_ready), 128'd1);
    checkOutput("bp_release_out_valid", 128'(out_valid), 128'd0);
    sendBlock(B_PT, B_CT, acc1);
    drain();

    // Key order error, then full reload.
    expandKey(C1_KEY);
    sendKey(0);
    sendKey(1);
    sendKey(3);
    checkOutput("order_key_err", 128'(key_err), 128'd1);
    checkOutput("order_keys_ready", 128'(keys_ready), 128'd0);
    checkOutput("order_in_ready", 128'(in_ready), 128'd0);
    loadKeys(C1_KEY);
    checkOutput("reload_key_err", 128'(key_err), 128'd0);
    checkOutput("reload_keys_ready", 128'(keys_ready), 128'd1);
    sendBlock(C1_PT, C1_CT, acc1);
    drain();

    // Key strobe while a block is in flight.
    sendBlock(C1_PT, C1_CT, acc1);
    idle(2);
    applyStimulus(1'b1, 4'd0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b0, '0);
    checkOutput("busy_key_err", 128'(key_err), 128'd1);
    checkOutput("busy_keys_ready", 128'(keys_ready), 128'd1);
    drain();

    // Reset at round 5, then no block may be accepted without a reload.
    sendBlock(C1_PT, C1_CT, acc1);
    idle(4);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("midrst_keys_ready", 128'(keys_ready), 128'd0);
    checkOutput("midrst_key_err", 128'(key_err), 128'd0);
    checkOutput("midrst_in_ready", 128'(in_ready), 128'd0);
    checkOutput("midrst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("midrst_out_block", out_block, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      saw = saw | in_ready;
      applyStimulus(1'b0, 4'd0, '0, 1'b1, C1_PT);
    end
    checkOutput("postrst_in_ready_seen", 128'(saw), 128'd0);
    checkOutput("postrst_keys_ready", 128'(keys_ready), 128'd0);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
